// File: rtl/mem_access_pkg.sv
// Shared encodings for the CPU data-memory access unit: size codes and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } mau_state_e;

    // Request fields captured at accept and held for the whole transaction.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mau_req_t;

    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_RSVD) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: extracts/extends load lanes and merges store lanes into a word.
// Purely combinational; no state, no handshake.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] mask;
    logic [4:0]  st_sh;

    always_comb begin
        byte_sh = {lane_i, 3'b000};
        half_sh = {lane_i[1], 4'b0000};
        byte_v  = 8'(word_i >> byte_sh);
        half_v  = 16'(word_i >> half_sh);
        load_o  = word_i;
        mask    = 32'hFFFF_FFFF;
        st_sh   = 5'd0;
        unique case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & byte_v[7]}}, byte_v};
                mask   = 32'h0000_00FF << byte_sh;
                st_sh  = byte_sh;
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & half_v[15]}}, half_v};
                mask   = 32'h0000_FFFF << half_sh;
                st_sh  = half_sh;
            end
            default: begin
                load_o = word_i;
                mask   = 32'hFFFF_FFFF;
                st_sh  = 5'd0;
            end
        endcase
        // Store data arrives right-aligned; slide it onto the addressed lanes.
        merge_o = (word_i & ~mask) | ((wdata_i << st_sh) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit to a word-wide data memory with sub-word read-modify-write.
// Accept-to-response 1/2/3 cycles (error / load or word store / sub-word store); response held until resp_ready.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] add,
    output logic [31:0] wd,
    output logic        mw,
    output logic        mre,
    input  logic [31:0] rd
);

    localparam logic [31:0] WORDS_LIM = MEM_WORDS;

    mau_state_e  state_q, state_d;
    mau_req_t    req_q, req_d;
    logic        err_q, err_d;
    logic [31:0] rword_q, rword_d;

    logic        req_bad;
    logic [31:0] req_widx;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_widx  = {2'b00, req_addr[31:2]};
    assign req_bad   = size_misaligned(req_size, req_addr[1:0]) || (req_widx >= WORDS_LIM);
    assign word_addr = {req_q.addr[31:2], 2'b00};

    // Fed from the captured memory word so load results and merged stores stay stable.
    mau_lane_align u_lane_align (
        .word_i   (rword_q),
        .lane_i   (req_q.addr[1:0]),
        .size_i   (req_q.size),
        .signed_i (req_q.sgn),
        .wdata_i  (req_q.wdata),
        .load_o   (load_data),
        .merge_o  (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rword_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rword_q <= rword_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        err_d      = err_q;
        rword_d    = rword_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mre        = 1'b0;
        mw         = 1'b0;
        add        = '0;
        wd         = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.size  = req_size;
                    req_d.sgn   = req_signed;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    err_d       = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        // Loads and sub-word stores both need the current word first.
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mre     = 1'b1;
                add     = word_addr;
                rword_d = rd;
                state_d = req_q.we ? WRITE : RESP;
            end
            WRITE: begin
                mw      = 1'b1;
                add     = word_addr;
                wd      = merged;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !req_q.we) begin
                    resp_rdata = load_data;
                end
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic against a word-array reference model.
module tb_mem_access_unit;

    localparam int MW = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] add, wd, rd;
    logic        mw, mre;

    logic [31:0] mem     [0:MW-1];
    logic [31:0] ref_mem [0:MW-1];

    int tests_run = 0;
    int tests_failed = 0;

    // observed results of the last do_req
    logic [31:0] g_rdata;
    logic        g_err;
    int          g_lat, g_nmre, g_nmw, g_mre_at, g_mw_at, g_wait;
    // model expectations
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, e_mre, e_mw;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .add        (add),
        .wd         (wd),
        .mw         (mw),
        .mre        (mre),
        .rd         (rd)
    );

    assign rd = mem[add[8:2]];
    always @(negedge clk) if (mw) mem[add[8:2]] <= wd;

    // Reference model: plain arithmetic on a word array.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] word, val, mask;
        int sh, width;
        e_err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
                || ((addr / 4) >= MW);
        e_rdata = 32'h0; e_lat = 1; e_mre = 0; e_mw = 0;
        if (!e_err) begin
            word = ref_mem[addr / 4];
            if (!we) begin
                e_lat = 2; e_mre = 1;
                if (size == 2'd0) begin
                    val = (word >> (8 * addr[1:0])) & 32'hFF;
                    if (sgn && val >= 32'd128) val = val - 32'd256;
                end else if (size == 2'd1) begin
                    val = (word >> (16 * addr[1])) & 32'hFFFF;
                    if (sgn && val >= 32'd32768) val = val - 32'd65536;
                end else begin
                    val = word;
                end
                e_rdata = val;
            end else begin
                e_mw  = 1;
                e_mre = (size == 2'd2) ? 0 : 1;
                e_lat = (size == 2'd2) ? 2 : 3;
                width = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
                sh    = (size == 2'd0) ? 8 * addr[1:0] : (size == 2'd1) ? 16 * addr[1] : 0;
                mask  = (width == 32) ? 32'hFFFF_FFFF : (((32'd1 << width) - 32'd1) << sh);
                ref_mem[addr / 4] = (word & ~mask) | ((wdata << sh) & mask);
            end
        end
    endtask

    // Drives one request (called #1 after a posedge), records what the DUT did, completes the handshake.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        g_wait = 0; g_lat = 0; g_nmre = 0; g_nmw = 0; g_mre_at = 0; g_mw_at = 0;
        while (!req_ready && g_wait < 50) begin
            @(posedge clk); #1; g_wait++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        for (int k = 1; k <= 20; k++) begin
            if (mre) begin g_nmre++; g_mre_at = k; end
            if (mw)  begin g_nmw++;  g_mw_at = k; end
            if (mre && mw) g_nmw = 99;
            if (resp_valid) begin g_lat = k; break; end
            @(posedge clk); #1;
        end
        g_rdata = resp_rdata;
        g_err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, resp_valid, resp_err, mw, mre} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got rdy/vld/err/mw/mre=%b exp=10000", {req_ready, resp_valid, resp_err, mw, mre});
        end
        tests_run++;
        if ({add, wd, resp_rdata} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_data got add=%h wd=%h rdata=%h exp all 0", add, wd, resp_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        ref_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        tests_run++;
        if ({g_err, g_rdata} !== {1'b0, 32'h0000_0014}) begin
            tests_failed++;
            $display("FAIL load_word got err=%b rdata=%h exp err=0 rdata=00000014", g_err, g_rdata);
        end
        tests_run++;
        if (g_lat !== 2) begin
            tests_failed++;
            $display("FAIL load_word_lat got=%0d exp=2", g_lat);
        end
    endtask

    task automatic test_sub_loads();
        do_req(1'b0, 2'd0, 1'b1, 32'h15, 32'h0);
        tests_run++;
        if (g_rdata !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL load_sbyte got=%h exp=ffffff80", g_rdata);
        end
        do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        tests_run++;
        if (g_rdata !== 32'h0000_1122) begin
            tests_failed++;
            $display("FAIL load_uhalf got=%h exp=00001122", g_rdata);
        end
        do_req(1'b0, 2'd0, 1'b0, 32'h14, 32'h0);
        tests_run++;
        if (g_rdata !== 32'h0000_00FF || g_lat !== 2) begin
            tests_failed++;
            $display("FAIL load_ubyte got=%h lat=%0d exp=000000ff lat=2", g_rdata, g_lat);
        end
    endtask

    task automatic test_byte_store();
        ref_access(1'b1, 2'd0, 1'b0, 32'h17, 32'h1234_56AB);
        do_req(1'b1, 2'd0, 1'b0, 32'h17, 32'h1234_56AB);
        tests_run++;
        if (mem[5] !== 32'hAB22_80FF) begin
            tests_failed++;
            $display("FAIL store_byte_mem got=%h exp=ab2280ff", mem[5]);
        end
        tests_run++;
        if ({g_nmre, g_mre_at, g_nmw, g_mw_at} !== {32'd1, 32'd1, 32'd1, 32'd2}) begin
            tests_failed++;
            $display("FAIL store_byte_seq got mre n=%0d@%0d mw n=%0d@%0d exp 1@1 1@2", g_nmre, g_mre_at, g_nmw, g_mw_at);
        end
        tests_run++;
        if ({g_lat, g_err, g_rdata} !== {32'd3, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL store_byte_resp got lat=%0d err=%b rdata=%h exp 3 0 0", g_lat, g_err, g_rdata);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ad [3] = '{32'h11, 32'h200, 32'h10};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, sz[i], 1'b0, ad[i], 32'h0);
            tests_run++;
            if ({g_err, g_rdata, g_lat, g_nmre, g_nmw} !== {1'b1, 32'h0, 32'd1, 32'd0, 32'd0}) begin
                tests_failed++;
                $display("FAIL error_%0d got err=%b rdata=%h lat=%0d mre=%0d mw=%0d exp 1 0 1 0 0",
                         i, g_err, g_rdata, g_lat, g_nmre, g_nmw);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w;
        int n;
        exp_w = ref_mem[5];
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h14;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        // Competing store arrives while the response is stalled.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h18; req_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({resp_valid, req_ready, mw, mre, resp_rdata} !== {4'b1000, exp_w}) begin
                tests_failed++;
                $display("FAIL stall_%0d got vld/rdy/mw/mre=%b rdata=%h exp 1000 %h",
                         i, {resp_valid, req_ready, mw, mre}, resp_rdata, exp_w);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (mem[6] !== ref_mem[6] || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_ignore got mem6=%h rdy=%b exp %h 1", mem[6], req_ready, ref_mem[6]);
        end
    endtask

    task automatic test_back_to_back();
        ref_access(1'b1, 2'd1, 1'b0, 32'h1A, 32'h7777_A5A5);
        do_req(1'b1, 2'd1, 1'b0, 32'h1A, 32'h7777_A5A5);
        ref_access(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0);
        tests_run++;
        if ({g_wait, g_rdata, g_lat} !== {32'd0, e_rdata, 32'd2}) begin
            tests_failed++;
            $display("FAIL back_to_back got wait=%0d rdata=%h lat=%0d exp 0 %h 2", g_wait, g_rdata, g_lat, e_rdata);
        end
        tests_run++;
        if (e_rdata !== 32'hFFFF_A5A5) begin
            tests_failed++;
            $display("FAIL back_to_back_shalf got model=%h exp=ffffa5a5", e_rdata);
        end
    endtask

    task automatic test_reset_during_write();
        int n;
        logic seen;
        ref_access(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if ({mw, add, wd} !== {1'b1, 32'h20, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL rst_write_cycle got mw=%b add=%h wd=%h exp 1 00000020 deadbeef", mw, add, wd);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({resp_valid, req_ready, mw, mre} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL rst_write_state got vld/rdy/mw/mre=%b exp 0100", {resp_valid, req_ready, mw, mre});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if (mem[8] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL rst_write_mem got=%h exp=deadbeef", mem[8]);
        end
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; seen |= resp_valid; end
        tests_run++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_write_noresp got resp_seen=%b rdy=%b exp 0 1", seen, req_ready);
        end
    endtask

    task automatic test_random();
        logic        we, sgn;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        int          bad;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3)); wdata = $urandom;
            addr = 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) addr = addr | (32'($urandom_range(1, 255)) << 9);
            ref_access(we, size, sgn, addr, wdata);
            do_req(we, size, sgn, addr, wdata);
            tests_run++;
            if ({g_err, g_rdata, g_lat, g_nmre, g_nmw} !== {e_err, e_rdata, e_lat, e_mre, e_mw}) begin
                tests_failed++;
                $display("FAIL rand_%0d we=%b sz=%0d a=%h got err=%b rd=%h lat=%0d mre=%0d mw=%0d exp %b %h %0d %0d %0d",
                         i, we, size, addr, g_err, g_rdata, g_lat, g_nmre, g_nmw, e_err, e_rdata, e_lat, e_mre, e_mw);
            end
        end
        bad = 0;
        for (int j = 0; j < MW; j++) if (mem[j] !== ref_mem[j]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rand_memory got %0d differing words exp 0", bad);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; rst_n = 1'b0;
        for (int j = 0; j < MW; j++) begin
            mem[j] = $urandom;
            ref_mem[j] = mem[j];
        end
        mem[4] = 32'h0000_0014;  ref_mem[4] = 32'h0000_0014;
        mem[5] = 32'h1122_80FF;  ref_mem[5] = 32'h1122_80FF;
        test_reset();
        test_load_word();
        test_sub_loads();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_during_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
